i2c_arb: RTL and testbench

I2C_ARB -- requirements
Module: i2c_arb

---
 rtl/i2c_pkg.sv | 29 ++
 rtl/i2c_req_buf.sv | 35 +++
 rtl/i2c_arb.sv | 173 +++++++++++++++++
 tb/tb_i2c_arb.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types for the i2c arbiter: command field widths, FSM encoding,
// the command record carried by each requester buffer, and a helper for
// sizing the "wait for busy" timeout counter.
package i2c_pkg;

  localparam int DEV_W  = 8;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic [DEV_W-1:0]  device_id;
    logic              w_r;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
  } i2c_cmd_t;

  // Counter must be able to hold the value TMO_CYC itself.
  function automatic int tmo_cnt_w(input int tmo_cyc);
    return $clog2(tmo_cyc + 1);
  endfunction

endpackage

// File: rtl/i2c_req_buf.sv
// One-entry request buffer: captures a command on trig when empty and
// holds it (pend=1) until the arbiter clears it after service or abort.
module i2c_req_buf
  import i2c_pkg::*;
(
  input  logic     clk,
  input  logic     rstn,
  input  logic     i_trig,
  input  i2c_cmd_t i_cmd,
  input  logic     i_clr,
  output logic     o_pend,
  output i2c_cmd_t o_cmd
);

  logic     r_pend;
  i2c_cmd_t r_cmd;

  // Capture only into an empty buffer; a trig while pending is dropped.
  // i_clr is only asserted while pending, so it never races a capture.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pend <= 1'b0;
      r_cmd  <= '0;
    end else if (i_trig && !r_pend) begin
      r_pend <= 1'b1;
      r_cmd  <= i_cmd;
    end else if (i_clr) begin
      r_pend <= 1'b0;
    end
  end

  assign o_pend = r_pend;
  assign o_cmd  = r_cmd;

endmodule

// File: rtl/i2c_arb.sv
// Two-requester round-robin arbiter in front of a single shared i2c_dri.
// Handshake: a requester pulses rN_trig for one cycle; rN_busy stays high
// until its transaction completes or is aborted. Toward the driver, the
// command fields are stable while drv_pluse is high and until the arbiter
// returns to IDLE; the driver acknowledges by raising drv_busy and signals
// completion by dropping it. dbg_state exposes the FSM state.
module i2c_arb
  import i2c_pkg::*;
#(
  parameter int TMO_CYC = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              r0_trig,
  input  logic [DEV_W-1:0]  r0_device_id,
  input  logic              r0_w_r,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_data_in,
  output logic              r0_busy,
  output logic              r0_byte_over,
  output logic [DATA_W-1:0] r0_data_out,
  input  logic              r1_trig,
  input  logic [DEV_W-1:0]  r1_device_id,
  input  logic              r1_w_r,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_data_in,
  output logic              r1_busy,
  output logic              r1_byte_over,
  output logic [DATA_W-1:0] r1_data_out,
  output logic [DEV_W-1:0]  drv_device_id,
  output logic              drv_pluse,
  output logic              drv_w_r,
  output logic [ADDR_W-1:0] drv_addr,
  output logic [DATA_W-1:0] drv_data_in,
  input  logic              drv_busy,
  input  logic              drv_byte_over,
  input  logic [DATA_W-1:0] drv_data_out,
  output logic              err_tmo,
  output arb_state_e        dbg_state
);

  localparam int TMO_W = tmo_cnt_w(TMO_CYC);

  arb_state_e       r_state, w_state_nxt;
  logic             r_grant, r_last;
  logic [TMO_W-1:0] r_tmo;
  i2c_cmd_t         r_drv_cmd;
  logic [DATA_W-1:0] r_data0, r_data1;

  logic     w_pend0, w_pend1, w_clr0, w_clr1;
  i2c_cmd_t w_cmd0, w_cmd1;
  logic     w_sel, w_load, w_release, w_done, w_pluse, w_err, w_active;

  i2c_req_buf u_buf0 (
    .clk    (clk),
    .rstn   (rstn),
    .i_trig (r0_trig),
    .i_cmd  ({r0_device_id, r0_w_r, r0_addr, r0_data_in}),
    .i_clr  (w_clr0),
    .o_pend (w_pend0),
    .o_cmd  (w_cmd0)
  );

  i2c_req_buf u_buf1 (
    .clk    (clk),
    .rstn   (rstn),
    .i_trig (r1_trig),
    .i_cmd  ({r1_device_id, r1_w_r, r1_addr, r1_data_in}),
    .i_clr  (w_clr1),
    .o_pend (w_pend1),
    .o_cmd  (w_cmd1)
  );

  // Next-state and per-cycle strobes; grant choice is round-robin on a tie.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_release   = 1'b0;
    w_done      = 1'b0;
    w_pluse     = 1'b0;
    w_err       = 1'b0;
    w_sel       = (w_pend0 && w_pend1) ? ~r_last : w_pend1;
    case (r_state)
      ST_IDLE: begin
        if ((w_pend0 || w_pend1) && !drv_busy) begin
          w_load      = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_pluse     = 1'b1;
        w_state_nxt = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (drv_busy) begin
          w_state_nxt = ST_WAIT_DONE;
        end else if (r_tmo == TMO_W'(TMO_CYC - 1)) begin
          w_err       = 1'b1;
          w_release   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (!drv_busy) begin
          w_release   = 1'b1;
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Cycles spent in WAIT_BUSY; zero in every other state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                        r_tmo <= '0;
    else if (r_state != ST_WAIT_BUSY) r_tmo <= '0;
    else                              r_tmo <= r_tmo + TMO_W'(1);
  end

  // Grant and driver command are latched on IDLE->ISSUE; last-grant only
  // advances on a completed transaction, not on a timeout abort.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_grant   <= 1'b0;
      r_last    <= 1'b1;
      r_drv_cmd <= '0;
    end else begin
      if (w_load) begin
        r_grant   <= w_sel;
        r_drv_cmd <= w_sel ? w_cmd1 : w_cmd0;
      end
      if (w_done) r_last <= r_grant;
    end
  end

  assign w_active = (r_state == ST_WAIT_BUSY) || (r_state == ST_WAIT_DONE);
  assign w_clr0   = w_release && !r_grant;
  assign w_clr1   = w_release &&  r_grant;

  assign r0_byte_over = drv_byte_over && w_active && !r_grant;
  assign r1_byte_over = drv_byte_over && w_active &&  r_grant;

  // Read data is captured only on a byte_over routed to that requester.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_data0 <= '0;
      r_data1 <= '0;
    end else begin
      if (r0_byte_over) r_data0 <= drv_data_out;
      if (r1_byte_over) r_data1 <= drv_data_out;
    end
  end

  assign r0_busy       = w_pend0;
  assign r1_busy       = w_pend1;
  assign r0_data_out   = r_data0;
  assign r1_data_out   = r_data1;
  assign drv_pluse     = w_pluse;
  assign err_tmo       = w_err;
  assign drv_device_id = r_drv_cmd.device_id;
  assign drv_w_r       = r_drv_cmd.w_r;
  assign drv_addr      = r_drv_cmd.addr;
  assign drv_data_in   = r_drv_cmd.data_in;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_i2c_arb.sv
// Bench for i2c_arb: a behavioural i2c_dri model answers drv_pluse, a
// monitor pops the expected command queue on every drv_pluse, and directed
// sequences cover latency, round-robin, read routing, timeout and reset.
`timescale 1ns/1ps
module tb_i2c_arb;
  import i2c_pkg::*;

  logic              clk, rstn;
  logic              r0_trig, r0_w_r, r0_busy, r0_byte_over;
  logic [7:0]        r0_device_id, r0_data_in, r0_data_out;
  logic [15:0]       r0_addr;
  logic              r1_trig, r1_w_r, r1_busy, r1_byte_over;
  logic [7:0]        r1_device_id, r1_data_in, r1_data_out;
  logic [15:0]       r1_addr;
  logic [7:0]        drv_device_id, drv_data_in, drv_data_out;
  logic              drv_pluse, drv_w_r, drv_busy, drv_byte_over, err_tmo;
  logic [15:0]       drv_addr;
  arb_state_e        dbg_state;

  logic [32:0] exp_q[$];
  int n_checks = 0, n_fail = 0, cyc = 0;
  int pl_cnt = 0, pl_prev = 0, pl_last = 0;
  bit tb_last = 1'b1;
  bit mdl_respond = 1'b1;
  int mdl_busy_len = 20;
  logic [7:0] mdl_rd_data = 8'h00;

  i2c_arb #(.TMO_CYC(16)) dut (
    .clk(clk), .rstn(rstn),
    .r0_trig(r0_trig), .r0_device_id(r0_device_id), .r0_w_r(r0_w_r),
    .r0_addr(r0_addr), .r0_data_in(r0_data_in), .r0_busy(r0_busy),
    .r0_byte_over(r0_byte_over), .r0_data_out(r0_data_out),
    .r1_trig(r1_trig), .r1_device_id(r1_device_id), .r1_w_r(r1_w_r),
    .r1_addr(r1_addr), .r1_data_in(r1_data_in), .r1_busy(r1_busy),
    .r1_byte_over(r1_byte_over), .r1_data_out(r1_data_out),
    .drv_device_id(drv_device_id), .drv_pluse(drv_pluse), .drv_w_r(drv_w_r),
    .drv_addr(drv_addr), .drv_data_in(drv_data_in), .drv_busy(drv_busy),
    .drv_byte_over(drv_byte_over), .drv_data_out(drv_data_out),
    .err_tmo(err_tmo), .dbg_state(dbg_state)
  );

  // Clock and cycle counter
  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Driver model: busy from the cycle after drv_pluse for mdl_busy_len cycles;
  // a read returns mdl_rd_data with a one-cycle byte_over near the end.
  initial begin
    drv_busy = 1'b0; drv_byte_over = 1'b0; drv_data_out = 8'h00;
    forever begin
      @(negedge clk);
      if (drv_pluse && mdl_respond) begin
        for (int i = 0; i < mdl_busy_len; i++) begin
          @(negedge clk);
          drv_busy      = 1'b1;
          drv_byte_over = (i == mdl_busy_len - 2) && !drv_w_r;
          drv_data_out  = mdl_rd_data;
        end
        @(negedge clk);
        drv_busy = 1'b0; drv_byte_over = 1'b0;
      end
    end
  end

  // Scoreboard monitor: every issued command must match the queue head.
  initial forever begin
    logic [32:0] exp_c;
    @(negedge clk); #1;
    if (drv_pluse) begin
      pl_cnt++; pl_prev = pl_last; pl_last = cyc;
      if (exp_q.size() == 0) check("pluse_unexpected", 1, 0);
      else begin
        exp_c = exp_q.pop_front();
        check("drv_cmd", {drv_device_id, drv_w_r, drv_addr, drv_data_in}, exp_c);
      end
    end
  end

  task automatic set_fields(input int n, input i2c_cmd_t c);
    if (n == 0) begin
      r0_device_id = c.device_id; r0_w_r = c.w_r; r0_addr = c.addr; r0_data_in = c.data_in;
    end else begin
      r1_device_id = c.device_id; r1_w_r = c.w_r; r1_addr = c.addr; r1_data_in = c.data_in;
    end
  endtask

  // One-cycle trig; returns at the next negedge (trig already captured).
  task automatic drive_req(input int n, input i2c_cmd_t c, input bit push);
    set_fields(n, c);
    if (n == 0) r0_trig = 1'b1; else r1_trig = 1'b1;
    if (push) begin exp_q.push_back(c); tb_last = (n != 0); end
    @(negedge clk);
    r0_trig = 1'b0; r1_trig = 1'b0;
  endtask

  // Simultaneous trig; expected order follows the round-robin model.
  task automatic drive_both(input i2c_cmd_t c0, input i2c_cmd_t c1);
    set_fields(0, c0); set_fields(1, c1);
    r0_trig = 1'b1; r1_trig = 1'b1;
    if (tb_last) begin exp_q.push_back(c0); exp_q.push_back(c1); tb_last = 1'b1; end
    else begin exp_q.push_back(c1); exp_q.push_back(c0); tb_last = 1'b0; end
    @(negedge clk);
    r0_trig = 1'b0; r1_trig = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int bound);
    bit done = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      @(negedge clk); #1;
      if (dbg_state == ST_IDLE && !r0_busy && !r1_busy && !drv_busy) done = 1'b1;
    end
    if (!done) check(tag, 0, 1);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    exp_q.delete();
    tb_last = 1'b1;
  endtask

  initial begin
    int viol, p, e, k, cnt0, cnt1, pl_before;
    bit done;
    rstn = 1'b0;
    r0_trig = 0; r1_trig = 0;
    set_fields(0, '0); set_fields(1, '0);

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_r0_busy", r0_busy, 0);
    check("rst_r1_busy", r1_busy, 0);
    check("rst_pluse", drv_pluse, 0);
    check("rst_drv_cmd", {drv_device_id, drv_w_r, drv_addr, drv_data_in}, 0);
    check("rst_err_tmo", err_tmo, 0);
    check("rst_state", dbg_state, ST_IDLE);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Write from r0: latency, fields, busy release one cycle after drv_busy falls
    mdl_busy_len = 20;
    drive_req(0, '{8'h56, 1'b1, 16'h1281, 8'h0A}, 1);
    #1;
    check("lat_r0_busy_c1", r0_busy, 1);
    check("lat_pluse_c1", drv_pluse, 0);
    @(negedge clk); #1;
    check("lat_pluse_c2", drv_pluse, 1);
    check("wr_addr", drv_addr, 16'h1281);
    check("wr_dev", drv_device_id, 8'h56);
    @(negedge clk); #1;
    check("pluse_one_cycle", drv_pluse, 0);
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk); #1;
      if (!drv_busy) done = 1'b1;
    end
    check("busy_fall_seen", done, 1);
    check("r0_busy_at_fall", r0_busy, 1);
    check("addr_held", drv_addr, 16'h1281);
    @(negedge clk); #1;
    check("r0_busy_after_fall", r0_busy, 0);

    // Ties: r0 first after reset, r1 held meanwhile, back-to-back gap
    reset_dut();
    mdl_busy_len = 4;
    drive_both('{8'h10, 1'b1, 16'h0001, 8'h11}, '{8'h20, 1'b1, 16'h0002, 8'h22});
    viol = 0; done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk); #1;
      if (r0_busy && !r1_busy) viol++;
      if (dbg_state == ST_IDLE && !r0_busy && !r1_busy && !drv_busy) done = 1'b1;
    end
    check("tie1_done", done, 1);
    check("tie1_r1_busy_held", viol, 0);
    check("tie1_b2b_gap", pl_last - pl_prev, mdl_busy_len + 3);
    drive_both('{8'h30, 1'b1, 16'h0003, 8'h33}, '{8'h40, 1'b1, 16'h0004, 8'h44});
    wait_idle("tie2_timeout", 60);
    drive_req(0, '{8'h50, 1'b1, 16'h0005, 8'h55}, 1);
    wait_idle("single_timeout", 40);
    drive_both('{8'h60, 1'b1, 16'h0006, 8'h66}, '{8'h70, 1'b1, 16'h0007, 8'h77});
    wait_idle("tie3_timeout", 60);

    // Reads: r0 gets 0xA5, then r1 gets 0x3C with r0 untouched
    mdl_busy_len = 6; mdl_rd_data = 8'hA5;
    drive_req(0, '{8'hA0, 1'b0, 16'h0100, 8'h00}, 1);
    wait_idle("rd0_timeout", 40);
    check("rd0_data", r0_data_out, 8'hA5);
    mdl_rd_data = 8'h3C;
    drive_req(1, '{8'hA1, 1'b0, 16'h0200, 8'h00}, 1);
    cnt0 = 0; cnt1 = 0; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk); #1;
      if (r0_byte_over) cnt0++;
      if (r1_byte_over) cnt1++;
      if (dbg_state == ST_IDLE && !r1_busy && !drv_busy) done = 1'b1;
    end
    check("rd1_done", done, 1);
    check("rd1_byte_over_cnt", cnt1, 1);
    check("rd1_r0_byte_over_cnt", cnt0, 0);
    check("rd1_data", r1_data_out, 8'h3C);
    check("rd1_r0_data_kept", r0_data_out, 8'hA5);

    // Repeat trig while pending is ignored
    mdl_busy_len = 20;
    drive_req(0, '{8'h56, 1'b1, 16'h1234, 8'h77}, 1);
    k = 0;
    while (dbg_state != ST_WAIT_DONE && k < 20) begin @(negedge clk); #1; k++; end
    drive_req(0, '{8'h56, 1'b1, 16'hFFFF, 8'h77}, 0);
    repeat (3) @(negedge clk);
    #1;
    check("repeat_addr_held", drv_addr, 16'h1234);
    wait_idle("repeat_timeout", 40);
    repeat (5) @(negedge clk);
    #1;
    check("repeat_no_busy", r0_busy, 0);

    // Timeout: driver never answers; r1 waits and is issued next
    mdl_respond = 1'b0;
    drive_req(0, '{8'h0B, 1'b1, 16'h0BAD, 8'h01}, 1);
    drive_req(1, '{8'h0C, 1'b1, 16'h0CAD, 8'h02}, 1);
    #1;
    k = 0;
    while (!drv_pluse && k < 10) begin @(negedge clk); #1; k++; end
    p = cyc;
    k = 0;
    while (!err_tmo && k < 40) begin @(negedge clk); #1; k++; end
    e = cyc;
    check("tmo_seen", err_tmo, 1);
    check("tmo_latency", e - p, 16);
    @(negedge clk); #1;
    check("tmo_pulse_width", err_tmo, 0);
    check("tmo_r0_busy_clr", r0_busy, 0);
    check("tmo_r1_still_busy", r1_busy, 1);
    @(negedge clk); #1;
    check("tmo_next_issue", drv_pluse, 1);
    wait_idle("tmo_r1_timeout", 40);
    mdl_respond = 1'b1;

    // Reset during WAIT_DONE with r1 also pending: everything discarded
    mdl_busy_len = 20;
    drive_req(0, '{8'h99, 1'b1, 16'h4321, 8'h5A}, 1);
    drive_req(1, '{8'h98, 1'b1, 16'h8765, 8'hA5}, 0);
    k = 0;
    while (dbg_state != ST_WAIT_DONE && k < 20) begin @(negedge clk); #1; k++; end
    check("rstmid_in_wait_done", dbg_state, ST_WAIT_DONE);
    pl_before = pl_cnt;
    rstn = 1'b0;
    #1;
    check("rstmid_r0_busy", r0_busy, 0);
    check("rstmid_r1_busy", r1_busy, 0);
    check("rstmid_drv_cmd", {drv_device_id, drv_w_r, drv_addr, drv_data_in}, 0);
    check("rstmid_r0_data", r0_data_out, 0);
    check("rstmid_state", dbg_state, ST_IDLE);
    @(negedge clk);
    rstn = 1'b1;
    exp_q.delete();
    repeat (40) @(negedge clk);
    #1;
    check("rstmid_no_pluse", pl_cnt, pl_before);
    check("rstmid_r1_busy_after", r1_busy, 0);

    check("exp_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
